// File: rtl/tune_pkg.sv
// Shared types, note constants and the tune ROM for the piezo tune sequencer.
package tune_pkg;

  localparam logic [15:0] C6 = 16'd47778;
  localparam logic [15:0] G6 = 16'd31887;
  localparam logic [15:0] C7 = 16'd23889;
  localparam logic [15:0] E7 = 16'd18960;
  localparam logic [15:0] G7 = 16'd15944;
  localparam logic [15:0] REST = 16'd0;

  localparam logic [24:0] D22    = 25'd4194304;
  localparam logic [24:0] D23    = 25'd8388608;
  localparam logic [24:0] D24    = 25'd16777216;
  localparam logic [24:0] D23_22 = 25'd12582912;

  typedef struct packed {
    logic [15:0] period;
    logic [24:0] dur;
    logic        last;
  } note_t;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  // Unused slots read back as a short terminating rest.
  function automatic note_t tune_rom(input logic [1:0] tune, input logic [7:0] idx);
    note_t n;
    n = '{REST, D22, 1'b1};
    case (tune)
      2'd0: begin
        case (idx)
          8'd0: n = '{G6, D23, 1'b0};
          8'd1: n = '{C7, D23, 1'b0};
          8'd2: n = '{E7, D23, 1'b0};
          8'd3: n = '{G7, D23_22, 1'b0};
          8'd4: n = '{E7, D22, 1'b0};
          8'd5: n = '{G7, D24, 1'b1};
          default: ;
        endcase
      end
      2'd1: begin
        case (idx)
          8'd0: n = '{C6, D22, 1'b0};
          8'd1: n = '{REST, D22, 1'b0};
          8'd2: n = '{C6, D22, 1'b1};
          default: ;
        endcase
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [15:0] note_period(input logic [1:0] tune, input logic [7:0] idx);
    note_t n;
    n = tune_rom(tune, idx);
    return n.period;
  endfunction

  function automatic logic [24:0] note_dur(input logic [1:0] tune, input logic [7:0] idx);
    note_t n;
    n = tune_rom(tune, idx);
    return n.dur;
  endfunction

  function automatic logic note_last(input logic [1:0] tune, input logic [7:0] idx);
    note_t n;
    n = tune_rom(tune, idx);
    return n.last;
  endfunction

endpackage

// File: rtl/tune_player_tone_gen.sv
// Square-wave generator: period counter plus duty compare, with registered drive pins.
module tone_gen #(
  parameter int DUTY_PCT = 70
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] period,
  output logic        piezo,
  output logic        piezo_n
);

  logic [15:0] per_cnt;
  logic [15:0] nxt_cnt;
  logic [31:0] high_cnt;
  logic        sounding;
  logic        on;

  // en/start/period describe the coming cycle, so the registered pins line up with per_cnt.
  always_comb begin
    high_cnt = (32'(period) * 32'(DUTY_PCT)) / 32'd100;
    if (!en || start || ((32'(per_cnt) + 32'd1) >= 32'(period)))
      nxt_cnt = '0;
    else
      nxt_cnt = per_cnt + 16'd1;
    sounding = en && (period != 16'd0);
    on = 32'(nxt_cnt) < high_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      piezo   <= 1'b0;
      piezo_n <= 1'b0;
    end else begin
      per_cnt <= nxt_cnt;
      piezo   <= sounding && on;
      piezo_n <= sounding && !on;
    end
  end

endmodule

// File: rtl/tune_player.sv
// Piezo tune sequencer: steps through a ROM tune note by note with optional
// silent gaps, abort, busy/done status and the index of the sounding note.
module tune_player
  import tune_pkg::*;
#(
  parameter int FAST_SIM  = 1,
  parameter int FAST_STEP = 16,
  parameter int DUTY_PCT  = 70,
  parameter int GAP_CYC   = 0,
  parameter int NUM_TUNES = 2,
  parameter int MAX_NOTES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic [((NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1)-1:0] tune_sel,
  input  logic abort,
  output logic piezo,
  output logic piezo_n,
  output logic busy,
  output logic done,
  output logic [$clog2(MAX_NOTES)-1:0] note_idx
);

  localparam int IDX_W  = $clog2(MAX_NOTES);
  localparam int TSEL_W = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1;
  localparam int STEP   = (FAST_SIM != 0) ? FAST_STEP : 1;

  state_t            state;
  state_t            nxt_state;
  logic [TSEL_W-1:0] tune;
  logic [TSEL_W-1:0] nxt_tune;
  logic [IDX_W-1:0]  nxt_idx;
  logic [24:0]       dur_cnt;
  logic [24:0]       cur_dur;
  logic              is_last;
  logic              note_end;
  logic              gap_end;
  logic              en_next;
  logic              start_next;
  logic [15:0]       nxt_period;

  // Next-state decisions; abort always wins over a note ending in the same cycle.
  always_comb begin
    cur_dur  = note_dur(2'(tune), 8'(note_idx));
    is_last  = note_last(2'(tune), 8'(note_idx)) || (note_idx == IDX_W'(MAX_NOTES - 1));
    note_end = ({1'b0, dur_cnt} + 26'(STEP)) >= {1'b0, cur_dur};
    gap_end  = 32'(dur_cnt) == (32'(GAP_CYC) - 32'd1);
    nxt_state = state;
    nxt_tune  = tune;
    nxt_idx   = note_idx;
    case (state)
      IDLE: begin
        if (go && !abort) begin
          nxt_state = TONE;
          nxt_tune  = tune_sel;
          nxt_idx   = '0;
        end
      end
      TONE: begin
        if (abort) begin
          nxt_state = IDLE;
          nxt_idx   = '0;
        end else if (note_end) begin
          if (is_last) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
          end else if (GAP_CYC > 0) begin
            nxt_state = GAP;
          end else begin
            nxt_idx = note_idx + IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (abort) begin
          nxt_state = IDLE;
          nxt_idx   = '0;
        end else if (gap_end) begin
          nxt_state = TONE;
          nxt_idx   = note_idx + IDX_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
    en_next    = (nxt_state == TONE);
    start_next = en_next && ((state != TONE) || note_end);
    nxt_period = note_period(2'(nxt_tune), 8'(nxt_idx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tune     <= '0;
      note_idx <= '0;
      dur_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= nxt_state;
      tune     <= nxt_tune;
      note_idx <= nxt_idx;
      done     <= (state == TONE) && !abort && note_end && is_last;
      if ((nxt_state != state) || start_next)
        dur_cnt <= '0;
      else if (state == TONE)
        dur_cnt <= dur_cnt + 25'(STEP);
      else if (state == GAP)
        dur_cnt <= dur_cnt + 25'd1;
      else
        dur_cnt <= '0;
    end
  end

  assign busy = (state != IDLE);

  tone_gen #(
    .DUTY_PCT(DUTY_PCT)
  ) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en_next),
    .start  (start_next),
    .period (nxt_period),
    .piezo  (piezo),
    .piezo_n(piezo_n)
  );

endmodule

// File: doc/tune_player.md
Name: tune_player

Overview:
- Parametrised piezo tune sequencer. It plays one of several stored tunes, selected by `tune_sel`, as a sequence of square-wave notes with a configurable duty cycle.
- Successor to the single-fanfare charge block. Adds tune selection, rest notes, an inter-note gap, abort, a busy flag, a done pulse, and a current-note index.
- Sits between the command processor (go/abort) and the piezo driver pins.

Parameters:
- FAST_SIM, 1, duration counter step: 16 when 1, 1 when 0.
- DUTY_PCT, 70, high portion of each note period in percent (1..99).
- GAP_CYC, 0, silent cycles inserted between notes (0 = no gap state).
- NUM_TUNES, 2, number of tunes in the ROM (1..4).
- MAX_NOTES, 8, maximum notes per tune; sets the note index width IDX_W = $clog2(MAX_NOTES).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  start request, sampled in IDLE only.
- tune_sel  in  $clog2(NUM_TUNES)  tune select, latched when go is accepted.
- abort  in  1  stop playback immediately.
- piezo  out  1  piezo drive.
- piezo_n  out  1  complementary piezo drive.
- busy  out  1  high while a tune is playing.
- done  out  1  one-cycle pulse when a tune completes normally.
- note_idx  out  IDX_W  index of the note currently sounding.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; all counters 0; piezo=0, piezo_n=0, busy=0, done=0, note_idx=0.
- ROM entry format: {period[15:0], dur[24:0], last}.
  - period=0 is a rest: piezo=piezo_n=0 for the full duration.
  - `last` marks the final note of a tune.
- States: IDLE, TONE, GAP.
- IDLE:
  - Outputs piezo=piezo_n=0.
  - When go=1 and abort=0: latch tune_sel, set note_idx=0, clear both counters, move to TONE on the next edge.
- TONE:
  - per_cnt counts 0..period-1 and wraps to 0.
  - high_cnt = (period*DUTY_PCT)/100, truncated, computed at 32-bit width.
  - piezo = (per_cnt < high_cnt); piezo_n = ~piezo. Rests override both to 0.
  - dur_cnt increments by STEP each cycle.
  - Note ends on the cycle where dur_cnt+STEP >= dur. Use 26-bit compare so the sum cannot overflow and a non-multiple duration cannot be missed.
  - Note length is therefore ceil(dur/STEP) cycles.
- Note end, registered on the next edge:
  - If last=1: go to IDLE and assert done for exactly 1 cycle.
  - Else if GAP_CYC>0: go to GAP.
  - Else: go to TONE with note_idx+1.
  - In every case both counters clear.
  - Each note starts with per_cnt=0, so piezo is high in its first cycle unless it is a rest.
- GAP:
  - piezo=piezo_n=0 for GAP_CYC cycles.
  - Then go to TONE with note_idx+1.
- busy = (state != IDLE). busy is 0 in the same cycle done is 1.
- abort=1 in TONE or GAP:
  - Next edge returns to IDLE; counters clear; piezo=piezo_n=0 from that edge.
  - No done pulse.
  - abort has priority over note end in the same cycle.
  - abort in IDLE has no effect.
- go while busy is ignored. tune_sel changes while busy are ignored.
- Index guard: if note_idx reaches MAX_NOTES-1 without last=1, that note is treated as last.
- piezo and piezo_n are registered outputs: one cycle of latency from the counter values.

Decomposition:
- tune_pkg holds:
  - Note period constants: G6=31887, C7=23889, E7=18960, G7=15944, C6=47778.
  - Duration constants: D22=2^22, D23=2^23, D24=2^24, D23_22=2^23+2^22.
  - Packed note_t typedef.
  - State enum.
  - Function `tune_rom(tune, idx)` returning note_t.
- Tune 0 (charge): G6 D23, C7 D23, E7 D23, G7 D23_22, E7 D22, G7 D24 (last).
- Tune 1 (error): C6 D22, rest D22, C6 D22 (last).
- Sub-module `tone_gen`: per_cnt plus duty compare, with inputs period and en and output piezo.

Test Plan:
- FAST_SIM=1, tune_sel=0, pulse go → busy=1 one cycle later; note_idx=0; piezo period 31887 cycles, 22320 high / 9567 low; note lasts 524288 cycles; then note_idx=1 with period 23889.
- Full tune 0 → note_idx steps 0..5. Note lengths 524288, 524288, 524288, 786432, 262144, 1048576 cycles. done is a single-cycle pulse after note 5; busy=0 in the same cycle; piezo=piezo_n=0 thereafter.
- tune_sel=1, GAP_CYC=100 → piezo=piezo_n=0 during the rest note (262144 cycles) and during each 100-cycle gap; 3 notes total; then done.
- abort asserted 1000 cycles into note 2 → next cycle: IDLE, busy=0, piezo=piezo_n=0, done never asserted. A subsequent go restarts from note_idx=0.
- go pulsed mid-tune with tune_sel toggled → ignored; the tune continues unchanged. Both abort and go in IDLE in the same cycle → stays IDLE.
- rst_n asserted mid-note asynchronously → all outputs 0 immediately without waiting for a clock edge. After release, idle until go.
